// File: rtl/instruction_cache_if.sv
// Fetch-side and main-memory-side signal bundle for instruction_cache.
// The slave modport is the cache's view; the master modport is the view of the fetch unit and main memory.
interface instruction_cache_if;
  logic         READ;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  modport slave (
    input  READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, 16-byte lines, filled from a block-wide memory port.
// Optional macro ICACHE_PERF_COUNTERS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module instruction_cache #(
  parameter int NUM_LINES = 8
) (
  input  logic                CLK,
  input  logic                RESET,
`ifdef ICACHE_PERF_COUNTERS_EN
  output logic [31:0]         HIT_COUNT,
  output logic [31:0]         MISS_COUNT,
`endif
  instruction_cache_if.slave  bus
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - 4 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    FILL
  } state_e;

  state_e               state_q;
  logic [27:0]          miss_addr_q;
  logic                 mem_read_q;
  logic [127:0]         fill_data_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  logic [INDEX_W-1:0]   req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [1:0]           req_word;
  logic [INDEX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 hit;
  logic                 busywait;
  logic [31:0]          instruction;
  logic                 addr_unused;

  assign req_idx     = bus.ADDRESS[3+INDEX_W:4];
  assign req_tag     = bus.ADDRESS[31:4+INDEX_W];
  assign req_word    = bus.ADDRESS[3:2];
  assign fill_idx    = miss_addr_q[INDEX_W-1:0];
  assign fill_tag    = miss_addr_q[27:INDEX_W];
  assign addr_unused = ^bus.ADDRESS[1:0];

  // Hit depends only on ADDRESS/READ and stored state, never on BUSYWAIT, so no loop through the fetch unit.
  // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    hit         = bus.READ && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    instruction = 32'd0;
    if (hit) instruction = data_q[req_idx][{req_word, 5'd0} +: 32];
    busywait    = (state_q == IDLE) ? (bus.READ && !hit) : 1'b1;
  end

  assign bus.INSTRUCTION = instruction;
  assign bus.BUSYWAIT    = busywait;
  assign bus.MEM_READ    = mem_read_q;
  assign bus.MEM_ADDRESS = miss_addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      miss_addr_q <= 28'd0;
      mem_read_q  <= 1'b0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.READ && !hit) begin
            miss_addr_q <= bus.ADDRESS[31:4];
            mem_read_q  <= 1'b1;
            state_q     <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (!bus.MEM_BUSYWAIT) begin
            mem_read_q <= 1'b0;
            state_q    <= FILL;
          end
        end
        FILL: begin
          valid_q[fill_idx] <= 1'b1;
          state_q           <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: line data and tags are not reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge CLK) begin
    if (state_q == MEM_RD && !bus.MEM_BUSYWAIT) fill_data_q <= bus.MEM_READDATA;
    if (state_q == FILL) begin
      data_q[fill_idx] <= fill_data_q;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Only served IDLE cycles count as hits; a miss is counted once, on the IDLE-to-MEM_RD step.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else if (state_q == IDLE) begin
      if (hit && hit_count_q != 32'hFFFF_FFFF)
        hit_count_q <= hit_count_q + 32'd1;
      if (bus.READ && !hit && miss_count_q != 32'hFFFF_FFFF)
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: stimulus queues expected fetch and memory responses,
// a negedge monitor pops and compares whenever the cache serves a fetch or starts a block read.
module tb_instruction_cache;
  localparam int MEM_LAT = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  instruction_cache_if bus ();

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  instruction_cache #(.NUM_LINES(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
`ifdef ICACHE_PERF_COUNTERS_EN
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count),
`endif
    .bus        (bus)
  );

  // Main memory: word at byte address A is A ^ 0xDEADBEEF; MEM_BUSYWAIT drops in the MEM_LAT-th read cycle.
  int mem_cnt = 0;
  always @(posedge CLK) mem_cnt <= bus.MEM_READ ? mem_cnt + 1 : 0;

  function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
    return {blk, w, 2'b00} ^ 32'hDEAD_BEEF;
  endfunction

  assign bus.MEM_BUSYWAIT = !(bus.MEM_READ && mem_cnt == MEM_LAT - 1);
  assign bus.MEM_READDATA = {mem_word(bus.MEM_ADDRESS, 2'd3), mem_word(bus.MEM_ADDRESS, 2'd2),
                             mem_word(bus.MEM_ADDRESS, 2'd1), mem_word(bus.MEM_ADDRESS, 2'd0)};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] exp_instr_q[$];
  logic [27:0] exp_mem_q[$];
  logic        mem_read_prev = 1'b0;

  always @(negedge CLK) begin
    if (!RESET && bus.READ && !bus.BUSYWAIT) begin
      if (exp_instr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got %0h expected none", bus.INSTRUCTION);
      end else begin
        check("instr", bus.INSTRUCTION, exp_instr_q.pop_front());
      end
    end
    if (bus.MEM_READ && !mem_read_prev) begin
      if (exp_mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mem_read: got %0h expected none", bus.MEM_ADDRESS);
      end else begin
        check("mem_address", {4'd0, bus.MEM_ADDRESS}, {4'd0, exp_mem_q.pop_front()});
      end
    end
    mem_read_prev <= bus.MEM_READ;
  end

  // One fetch: a miss must stall 1 + MEM_LAT + 1 cycles with MEM_READ high for MEM_LAT of them.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_instr, input bit miss);
    int  stalls = 0;
    int  memc   = 0;
    bit  done   = 0;
    bus.ADDRESS = addr;
    bus.READ    = 1'b1;
    exp_instr_q.push_back(exp_instr);
    if (miss) exp_mem_q.push_back(addr[31:4]);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (bus.MEM_READ) memc++;
      if (!bus.BUSYWAIT) done = 1;
      else stalls++;
    end
    check("fetch_completed", 32'(done), 32'd1);
    check("stall_cycles", stalls, miss ? 32'd6 : 32'd0);
    check("mem_read_cycles", memc, miss ? 32'd4 : 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit done;
    RESET       = 1'b1;
    bus.READ    = 1'b0;
    bus.ADDRESS = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
    check("reset_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
    check("reset_mem_address", {4'd0, bus.MEM_ADDRESS}, 32'd0);
    check("reset_instr", bus.INSTRUCTION, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Cold miss, then sequential hits in the same line.
    fetch(32'h0000_0000, 32'hDEAD_BEEF, 1);
`ifdef ICACHE_PERF_COUNTERS_EN
    check("miss_count_cold", miss_count, 32'd1);
    check("hit_count_cold", hit_count, 32'd1);
`endif
    fetch(32'h0000_0004, 32'hDEAD_BEEB, 0);
    fetch(32'h0000_0008, 32'hDEAD_BEE7, 0);
    fetch(32'h0000_000C, 32'hDEAD_BEE3, 0);
`ifdef ICACHE_PERF_COUNTERS_EN
    check("miss_count_seq", miss_count, 32'd1);
    check("hit_count_seq", hit_count, 32'd4);
`endif

    // READ low: an uncached address must not start a miss.
    bus.READ    = 1'b0;
    bus.ADDRESS = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("idle_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
      check("idle_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
    end
    @(posedge CLK);
    #1;

    // Conflict on index 0 evicts and reloads.
    fetch(32'h0000_0080, 32'hDEAD_BE6F, 1);
    fetch(32'h0000_0000, 32'hDEAD_BEEF, 1);

    // Highest address maps to the last line.
    fetch(32'hFFFF_FFFC, 32'h2152_4113, 1);
    fetch(32'hFFFF_FFFC, 32'h2152_4113, 0);

    // Address moves during MEM_RD: block 1 still fills, then 0x20 takes its own miss.
    bus.ADDRESS = 32'h0000_0010;
    bus.READ    = 1'b1;
    exp_mem_q.push_back(28'h000_0001);
    exp_mem_q.push_back(28'h000_0002);
    exp_instr_q.push_back(32'hDEAD_BECF);
    @(posedge CLK);
    #1;
    bus.ADDRESS = 32'h0000_0020;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (!bus.BUSYWAIT) done = 1;
    end
    check("moved_fetch_completed", 32'(done), 32'd1);
    @(posedge CLK);
    #1;
    fetch(32'h0000_0010, 32'hDEAD_BEFF, 0);
    fetch(32'h0000_0020, 32'hDEAD_BECF, 0);

    // Reset while a block read is in flight.
    bus.ADDRESS = 32'h0000_0080;
    bus.READ    = 1'b1;
    exp_mem_q.push_back(28'h000_0008);
    repeat (2) @(posedge CLK);
    #1;
    check("pre_reset_mem_read", {31'd0, bus.MEM_READ}, 32'd1);
    RESET    = 1'b1;
    bus.READ = 1'b0;
    @(posedge CLK);
    #1;
    check("abort_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
    check("abort_mem_address", {4'd0, bus.MEM_ADDRESS}, 32'd0);
    check("abort_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
    RESET = 1'b0;
    fetch(32'h0000_0000, 32'hDEAD_BEEF, 1);
    fetch(32'hFFFF_FFFC, 32'h2152_4113, 1);

    bus.READ = 1'b0;
    repeat (2) @(posedge CLK);
    check("instr_queue_drained", exp_instr_q.size(), 32'd0);
    check("mem_queue_drained", exp_mem_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
